// File: rtl/md_issue_ctrl.sv
// Issue controller between the EX stage and the multiply/divide unit.
// It sequences mult/div launches, HI/LO writes and mfhi/mflo reads.
module md_issue_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IssueValid,
  input  logic [2:0]  IssueOp,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        Flush,
  input  logic        MdBusy,
  input  logic [31:0] Hi,
  input  logic [31:0] Lo,
  output logic        IssueReady,
  output logic        Stall,
  output logic        MdStart,
  output logic [1:0]  MdOp,
  output logic [31:0] MdD1,
  output logic [31:0] MdD2,
  output logic        MdWe,
  output logic        MdHiLo,
  output logic        MfValid,
  output logic [31:0] MfData,
  output logic        DivZero,
  output logic        Timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;

  logic          accept_s;
  logic          is_muldiv_s;
  logic          is_div_s;
  logic          is_mt_s;
  logic          is_mf_s;
  logic          rt_zero_s;
  logic          launch_s;
  logic          write_s;
  logic          read_s;
  logic          divzero_s;
  logic          timeout_s;
  logic [31:0]   mf_data_s;

  logic          start_r;
  logic [1:0]    op_r;
  logic [31:0]   d1_r;
  logic [31:0]   d2_r;
  logic          we_r;
  logic          hilo_r;
  logic          mf_valid_r;
  logic [31:0]   mf_data_r;
  logic          divzero_r;
  logic          timeout_r;

  assign IssueReady  = (state_r == ST_IDLE);
  assign Stall       = IssueValid & ~Flush & ~IssueReady;
  assign accept_s    = IssueValid & IssueReady & ~Flush;

  assign is_muldiv_s = (IssueOp[2] == 1'b0);
  assign is_div_s    = (IssueOp[2:1] == 2'b01);
  assign is_mt_s     = (IssueOp[2:1] == 2'b10);
  assign is_mf_s     = (IssueOp[2:1] == 2'b11);
  assign rt_zero_s   = (RtData == 32'h0000_0000);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; WAIT leaves on a sampled idle unit or when the budget runs out
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_nxt_s = ST_LAUNCH;
        end else if (write_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (!MdBusy || (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WRITE: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: accept classification and next values of the pulse outputs
  always_comb begin
    launch_s  = accept_s & is_muldiv_s & ~(is_div_s & rt_zero_s);
    write_s   = accept_s & is_mt_s;
    read_s    = accept_s & is_mf_s;
    divzero_s = accept_s & is_div_s & rt_zero_s;
    timeout_s = (state_r == ST_WAIT) & MdBusy & (cnt_r == CNT_LAST);
    if (IssueOp[0]) begin
      mf_data_s = Lo;
    end else begin
      mf_data_s = Hi;
    end
  end

  // WAIT cycle counter, zero on entry
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Single-cycle strobes, aligned with the state they belong to
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      start_r    <= 1'b0;
      we_r       <= 1'b0;
      mf_valid_r <= 1'b0;
      divzero_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      start_r    <= (state_nxt_s == ST_LAUNCH);
      we_r       <= (state_nxt_s == ST_WRITE);
      mf_valid_r <= read_s;
      divzero_r  <= divzero_s;
      timeout_r  <= timeout_s;
    end
  end

  // Operand and HI/LO-select registers; held until the next accepted op that uses them
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_r   <= 2'b00;
      d1_r   <= 32'h0000_0000;
      d2_r   <= 32'h0000_0000;
      hilo_r <= 1'b0;
    end else if (launch_s) begin
      op_r   <= IssueOp[1:0];
      d1_r   <= RsData;
      d2_r   <= RtData;
      hilo_r <= hilo_r;
    end else if (write_s) begin
      op_r   <= op_r;
      d1_r   <= RsData;
      d2_r   <= d2_r;
      hilo_r <= ~IssueOp[0];
    end else begin
      op_r   <= op_r;
      d1_r   <= d1_r;
      d2_r   <= d2_r;
      hilo_r <= hilo_r;
    end
  end

  // mfhi/mflo capture; holds between reads
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mf_data_r <= 32'h0000_0000;
    end else if (read_s) begin
      mf_data_r <= mf_data_s;
    end else begin
      mf_data_r <= mf_data_r;
    end
  end

  assign MdStart = start_r;
  assign MdOp    = op_r;
  assign MdD1    = d1_r;
  assign MdD2    = d2_r;
  assign MdWe    = we_r;
  assign MdHiLo  = hilo_r;
  assign MfValid = mf_valid_r;
  assign MfData  = mf_data_r;
  assign DivZero = divzero_r;
  assign Timeout = timeout_r;

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent in WAIT before abort.
REQ-002 Clk  in  1  clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 IssueValid  in  1  EX stage presents an HI/LO-class instruction.
REQ-005 IssueOp  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
REQ-006 RsData, RtData  in  32 each  source operands.
REQ-007 Flush  in  1  squash the EX instruction this cycle.
REQ-008 MdBusy  in  1  Busy from the multiply/divide unit.
REQ-009 Hi, Lo  in  32 each  HI/LO from the multiply/divide unit.
REQ-010 IssueReady  out  1  instruction accepted this cycle.
REQ-011 Stall  out  1  hold the pipeline.
REQ-012 MdStart  out  1; MdOp  out  2; MdD1, MdD2  out  32; MdWe  out  1; MdHiLo  out  1  (1=HI)  unit control.
REQ-013 MfValid  out  1; MfData  out  32  mfhi/mflo result.
REQ-014 DivZero  out  1  pulse: divide by zero squashed.
REQ-015 Timeout  out  1  pulse: WAIT aborted.

Function
REQ-016 The state machine SHALL have states IDLE, LAUNCH, WAIT, and WRITE.
REQ-017 IssueReady SHALL equal (state==IDLE); accept = IssueValid & IssueReady & ~Flush.
REQ-018 Stall SHALL equal IssueValid & ~Flush & ~IssueReady, combinationally.
REQ-019 On accept of op 00x/01x with a nonzero divisor (or any mult), the block SHALL register IssueOp[1:0], RsData, and RtData, then go to LAUNCH.
REQ-020 In LAUNCH, the block SHALL drive MdStart=1, MdOp, MdD1=Rs, and MdD2=Rt from the registers for exactly one cycle, then go to WAIT.
REQ-021 In WAIT, the block SHALL go to IDLE on the cycle after MdBusy is sampled 0.
REQ-022 The WAIT counter SHALL be cleared on WAIT entry.
REQ-023 If TIMEOUT cycles elapse in WAIT without MdBusy being sampled 0, the block SHALL assert Timeout for one cycle and go to IDLE.
REQ-024 On accept of div/divu with RtData==0, the block SHALL issue no MdStart, pulse DivZero for one cycle starting next cycle, and remain in IDLE; HI/LO remain unchanged.
REQ-025 On accept of mthi/mtlo, the block SHALL go to WRITE.
REQ-026 In WRITE, the block SHALL drive MdWe=1, MdHiLo=~IssueOp[0] (registered), and MdD1=registered Rs for one cycle, then go to IDLE.
REQ-027 On accept of mfhi/mflo, the block SHALL register Hi or Lo into MfData and pulse MfValid for one cycle starting next cycle; state stays IDLE.
REQ-028 Back-to-back mf instructions SHALL be accepted every cycle.
REQ-029 Outside LAUNCH, the block SHALL hold MdStart=0; outside WRITE, it SHALL hold MdWe=0; MdOp, MdD1, and MdD2 SHALL hold their last registered values.
REQ-030 An mf accepted in the first IDLE cycle after WRITE or WAIT SHALL return the updated HI/LO.
REQ-031 Flush SHALL affect only the same-cycle issue; LAUNCH, WAIT, and WRITE already in progress SHALL complete.
REQ-032 Flush with IssueValid SHALL give Stall=0 and no accept.
REQ-033 MfData SHALL hold its value between pulses.

Reset
REQ-034 Rst SHALL force state=IDLE and clear the WAIT counter, all pulse outputs, MdOp, MdD1, MdD2, MdHiLo, and MfData to 0, asynchronously.
REQ-035 Rst mid-WAIT or mid-WRITE SHALL abandon the operation with no MdWe or MdStart afterwards.
REQ-036 Outputs SHALL be valid from the first edge after Rst falls.

Verification
REQ-037 The bench SHALL cover: mult Rs=3, Rt=0xFFFFFFFE -> one MdStart with MdOp=01; Stall high until IDLE; then mfhi -> MfData=0xFFFFFFFF and mflo -> MfData=0xFFFFFFFA.
REQ-038 The bench SHALL cover: divu Rs=7, Rt=2 -> after completion, mfhi=1 and mflo=3; IssueReady low for the entire LAUNCH+WAIT period.
REQ-039 The bench SHALL cover: div Rt=0 -> DivZero pulse, MdStart never asserted, IssueReady stays 1, and a following mflo returns the prior LO.
REQ-040 The bench SHALL cover: mtlo 0x12345678 then mflo on the next accepted cycle -> MfData=0x12345678; WRITE takes exactly one cycle.
REQ-041 The bench SHALL cover: MdBusy forced to 1 -> Timeout pulses after 15 WAIT cycles and the block returns to IDLE.
REQ-042 The bench SHALL cover: Rst asserted mid-WAIT -> immediate IDLE with all outputs 0; and Flush with IssueValid -> no accept and Stall=0.
